// File: rtl/alu_nibble_sequencer.sv
// Runs a wide 74181-style ALU operation through one 4-bit ALU slice, LSB nibble first,
// rippling the carry through a register and presenting the result behind valid/ready.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic [3:0]             in_s,
    input  logic                   in_m,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_f,
    output logic                   out_cout,
    output logic                   out_zero,
    output logic                   out_aeqb,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cn,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cn4,
    input  logic                   alu_aeqb
);

    localparam int W     = 4 * NIBBLES;
    localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NIB_W-1:0]   nib_q, nib_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [3:0]         s_q, s_d;
    logic               m_q, m_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       result_q, result_d;
    logic               aeqb_q, aeqb_d;
    logic               nib_last;

    assign nib_last = (nib_q == NIB_W'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            nib_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            aeqb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nib_q    <= nib_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            aeqb_q   <= aeqb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nib_d    = nib_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        carry_d  = carry_q;
        result_d = result_q;
        aeqb_d   = aeqb_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    s_d      = in_s;
                    m_d      = in_m;
                    carry_d  = in_cin;
                    result_d = '0;
                    aeqb_d   = 1'b1;
                    nib_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // ALU returns an active-low carry; the register holds it active-high
                result_d[4*nib_q +: 4] = alu_f;
                carry_d                = ~alu_cn4;
                aeqb_d                 = aeqb_q & alu_aeqb;
                if (nib_last) begin
                    nib_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    nib_d = nib_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_s     = 4'h0;
        alu_m     = 1'b0;
        alu_cn    = 1'b1;
        if (state_q == ST_RUN) begin
            alu_a  = a_q[4*nib_q +: 4];
            alu_b  = b_q[4*nib_q +: 4];
            alu_s  = s_q;
            alu_m  = m_q;
            alu_cn = ~carry_q;
        end
    end

    assign out_f    = result_q;
    assign out_cout = carry_q;
    assign out_aeqb = aeqb_q;
    assign out_zero = ~|result_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a behavioural 4-bit 74181 slice closes the ALU loop,
// and word-level arithmetic predicts each assembled result.
module tb_alu_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [3:0]  in_s = '0;
    logic        in_m = 1'b0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_f;
    logic        out_cout;
    logic        out_zero;
    logic        out_aeqb;
    logic [3:0]  alu_a, alu_b, alu_s, alu_f;
    logic        alu_m, alu_cn, alu_cn4, alu_aeqb;

    int n_checks = 0;
    int n_fail   = 0;

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_cout(out_cout), .out_zero(out_zero), .out_aeqb(out_aeqb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
        .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_aeqb(alu_aeqb)
    );

    always #5 clk = ~clk;

    // 4-bit 74181 slice, active-high data, active-low carries; A=B reports operand equality
    function automatic logic [5:0] alu181(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s, input logic m, input logic cn);
        logic [3:0] f;
        logic       c, x, y;
        c = ~cn;
        for (int i = 0; i < 4; i++) begin
            x    = ~((a[i] & b[i] & s[3]) | (a[i] & ~b[i] & s[2]));
            y    = ~(a[i] | (b[i] & s[0]) | (~b[i] & s[1]));
            f[i] = x ^ y ^ (m | c);
            c    = ~x | (~y & c);
        end
        return {f, ~c, (a == b)};
    endfunction

    always_comb {alu_f, alu_cn4, alu_aeqb} = alu181(alu_a, alu_b, alu_s, alu_m, alu_cn);

    // Word-level expectation {f, cout, zero, aeqb} for add, subtract and logic XOR
    function automatic logic [18:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op, input logic cin);
        logic [16:0] sum;
        logic [15:0] f;
        if (op == 2'd0) sum = {1'b0, a} + {1'b0, b} + 17'(cin);
        else            sum = {1'b0, a} + {1'b0, ~b} + 17'(cin);
        f = (op == 2'd2) ? (a ^ b) : sum[15:0];
        return {f, sum[16], (f == 16'h0), (a == b)};
    endfunction

    function automatic logic [4:0] op_sm(input logic [1:0] op);
        case (op)
            2'd0:    return {4'b1001, 1'b0};
            2'd1:    return {4'b0110, 1'b0};
            default: return {4'b0110, 1'b1};
        endcase
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input logic cin, output int lat);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in_a = a; in_b = b; {in_s, in_m} = op_sm(op); in_cin = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_s = 4'($urandom); in_m = 1'($urandom); in_cin = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
            if (lat == 2) in_a = ~in_a;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_f, out_cout, out_zero, out_aeqb} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b f=%h c=%b z=%b eq=%b, want rdy=1 vld=0 f=0000 c=0 z=1 eq=0",
                     in_ready, out_valid, out_f, out_cout, out_zero, out_aeqb);
        end
        n_checks++;
        if ({alu_a, alu_b, alu_s, alu_m, alu_cn} !== {4'h0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_alu_idle: got a=%h b=%h s=%h m=%b cn=%b, want 0 0 0 0 1",
                     alu_a, alu_b, alu_s, alu_m, alu_cn);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic [1:0] op, input logic cin, input logic [18:0] want);
        int lat;
        issue(a, b, op, cin, lat);
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, want 4", name, lat);
        end
        n_checks++;
        if ({out_f, out_cout, out_zero, out_aeqb} !== want) begin
            n_fail++;
            $display("FAIL %s_result: got f=%h c=%b z=%b eq=%b, want f=%h c=%b z=%b eq=%b", name,
                     out_f, out_cout, out_zero, out_aeqb, want[18:3], want[2], want[1], want[0]);
        end
        n_checks++;
        if ({alu_a, alu_b, alu_s, alu_m, alu_cn} !== {4'h0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_alu_idle_done: got a=%h b=%h s=%h m=%b cn=%b, want 0 0 0 0 1",
                     name, alu_a, alu_b, alu_s, alu_m, alu_cn);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [18:0] want;
        want = ref_op(16'h3A5C, 16'h1111, 2'd0, 1'b1);
        issue(16'h3A5C, 16'h1111, 2'd0, 1'b1, lat);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, out_f, out_cout} !== {1'b1, 1'b0, want[18:3], want[2]}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b f=%h c=%b, want vld=1 rdy=0 f=%h c=%b",
                         i, out_valid, in_ready, out_f, out_cout, want[18:3], want[2]);
            end
        end
        in_valid = 1'b0;
        drain();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        in_a = 16'hFFFF; in_b = 16'h0001; {in_s, in_m} = op_sm(2'd0); in_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, out_f, out_cout, out_aeqb} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got rdy=%b vld=%b f=%h c=%b eq=%b, want rdy=1 vld=0 f=0000 c=0 eq=0",
                     in_ready, out_valid, out_f, out_cout, out_aeqb);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_no_accept: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        test_fixed("reset_mid_add", 16'h1234, 16'h4321, 2'd0, 1'b0, {16'h5555, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] a, b;
        logic [1:0]  op;
        logic        cin;
        logic [18:0] want;
        for (int n = 0; n < 40; n++) begin
            a   = 16'($urandom);
            b   = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
            op  = 2'($urandom_range(0, 2));
            cin = 1'($urandom);
            want = ref_op(a, b, op, cin);
            issue(a, b, op, cin, lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            n_checks++;
            if (lat != 4 || {out_valid, out_f, out_cout, out_zero, out_aeqb} !== {1'b1, want}) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h cin=%b: got lat=%0d vld=%b f=%h c=%b z=%b eq=%b, want lat=4 vld=1 f=%h c=%b z=%b eq=%b",
                         n, op, a, b, cin, lat, out_valid, out_f, out_cout, out_zero, out_aeqb,
                         want[18:3], want[2], want[1], want[0]);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_fixed("add_carry",    16'h00FF, 16'h0001, 2'd0, 1'b0, {16'h0100, 1'b0, 1'b0, 1'b0});
        test_fixed("add_overflow", 16'hFFFF, 16'h0001, 2'd0, 1'b0, {16'h0000, 1'b1, 1'b1, 1'b0});
        test_fixed("sub_equal",    16'h1234, 16'h1234, 2'd1, 1'b1, {16'h0000, 1'b1, 1'b1, 1'b1});
        test_fixed("sub_borrow",   16'h1234, 16'h1235, 2'd1, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b0});
        test_fixed("logic_xor",    16'hF0F0, 16'hFF00, 2'd2, 1'b0, {16'h0FF0, 1'b0, 1'b0, 1'b0});
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
